// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
//
// Multithreaded instruction fetch stage feeding the decoder. Keeps a PC and an
// active bit per hardware thread, picks the next active thread round-robin,
// runs a single outstanding instruction-memory request at a time and parks
// the returned word in a one-entry output register tagged with its PC and
// thread ID until decode takes it.
//
// Parameters
//   NUM_TRD   number of hardware threads (power of two, >= 2)
//   RESET_PC  PC loaded into thread 0 at reset
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   imem_req/imem_addr         request valid + fetch PC, held until imem_gnt
//   imem_gnt                   request accepted this cycle
//   imem_rvalid/imem_rdata     one read response per grant
//   ins_valid/ins_ready        output handshake to decode
//   ins/ins_pc/ins_tid         instruction word, its PC and its thread
//   redirect_valid/_tid/_pc    branch/exception redirect of one thread's PC
//   trd_valid/trd_ctrl/trd_tid thread control: 001 sleep, 010 wake,
//   init_pc                    011 kill, 111 init (start PC in init_pc)
//   active_mask                per-thread active bits
// -----------------------------------------------------------------------------
module fetch #(
  parameter int          NUM_TRD  = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int         TW       = $clog2(NUM_TRD)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [31:0]        ins,
  output logic [31:0]        ins_pc,
  output logic [TW-1:0]      ins_tid,
  input  logic               redirect_valid,
  input  logic [TW-1:0]      redirect_tid,
  input  logic [31:0]        redirect_pc,
  input  logic               trd_valid,
  input  logic [2:0]         trd_ctrl,
  input  logic [TW-1:0]      trd_tid,
  input  logic [31:0]        init_pc,
  output logic [NUM_TRD-1:0] active_mask
);

  localparam logic [2:0] CTRL_SLEEP = 3'b001;
  localparam logic [2:0] CTRL_WAKE  = 3'b010;
  localparam logic [2:0] CTRL_KILL  = 3'b011;
  localparam logic [2:0] CTRL_INIT  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q [NUM_TRD];
  logic [31:0]          pc_d [NUM_TRD];
  logic [NUM_TRD-1:0]   active_q, active_d;
  logic [TW-1:0]        rr_q, rr_d;
  logic                 squash_q, squash_d;

  logic                 imem_req_d;
  logic [31:0]          imem_addr_d;
  logic                 ins_valid_d;
  logic [31:0]          ins_d;
  logic [31:0]          ins_pc_d;
  logic [TW-1:0]        ins_tid_d;

  logic                 is_stop;
  logic                 squash_hit;
  logic                 drop_rsp;
  logic                 sel_found;
  logic [TW-1:0]        sel_tid;
  logic                 sel_stop;

  // First active thread at offset 1..NUM_TRD from the last pick. The loop
  // runs from the far end so the nearest hit is the one left standing.
  function automatic logic [TW:0] pick_next(input logic [NUM_TRD-1:0] mask,
                                            input logic [TW-1:0]      last);
    logic [TW-1:0] cand;
    pick_next = '0;
    for (int i = NUM_TRD; i >= 1; i--) begin
      cand = last + TW'(i);
      if (mask[cand]) pick_next = {1'b1, cand};
    end
  endfunction

  assign active_mask = active_q;

  // rr_q always names the thread whose fetch is in flight or held.
  assign is_stop    = trd_valid && (trd_ctrl == CTRL_SLEEP || trd_ctrl == CTRL_KILL);
  assign squash_hit = (redirect_valid && redirect_tid == rr_q) ||
                      (is_stop && trd_tid == rr_q);
  assign drop_rsp   = squash_q || squash_hit;

  assign {sel_found, sel_tid} = pick_next(active_q, rr_q);
  // A thread being stopped in the very cycle it is picked must not deliver.
  assign sel_stop = is_stop && trd_tid == sel_tid;

  // PC table and active bits. Later writes win: +4 write-back, then
  // redirect, then init.
  always_comb begin
    for (int t = 0; t < NUM_TRD; t++) pc_d[t] = pc_q[t];
    active_d = active_q;

    if (state_q == S_WAIT && imem_rvalid && !drop_rsp)
      pc_d[rr_q] = imem_addr + 32'd4;

    if (redirect_valid)
      pc_d[redirect_tid] = redirect_pc;

    if (trd_valid) begin
      case (trd_ctrl)
        CTRL_INIT: begin
          active_d[trd_tid] = 1'b1;
          pc_d[trd_tid]     = init_pc;
        end
        CTRL_WAKE:             active_d[trd_tid] = 1'b1;
        CTRL_SLEEP, CTRL_KILL: active_d[trd_tid] = 1'b0;
        default: ;
      endcase
    end
  end

  // Fetch control. The selected address is taken from pc_d so a redirect or
  // init landing in the selection cycle is not lost.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    squash_d    = squash_q;
    imem_req_d  = imem_req;
    imem_addr_d = imem_addr;
    ins_valid_d = ins_valid;
    ins_d       = ins;
    ins_pc_d    = ins_pc;
    ins_tid_d   = ins_tid;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          rr_d        = sel_tid;
          imem_addr_d = pc_d[sel_tid];
          imem_req_d  = 1'b1;
          squash_d    = sel_stop;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        if (squash_hit) squash_d = 1'b1;
        if (imem_gnt) begin
          imem_req_d = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          squash_d = 1'b0;
          if (drop_rsp) begin
            state_d = S_IDLE;
          end else begin
            ins_d       = imem_rdata;
            ins_pc_d    = imem_addr;
            ins_tid_d   = rr_q;
            ins_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end else if (squash_hit) begin
          squash_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (squash_hit) begin
          ins_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (ins_ready) begin
          ins_valid_d = 1'b0;
          if (sel_found) begin
            rr_d        = sel_tid;
            imem_addr_d = pc_d[sel_tid];
            imem_req_d  = 1'b1;
            squash_d    = sel_stop;
            state_d     = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_q      <= {TW{1'b1}};
      squash_q  <= 1'b0;
      active_q  <= NUM_TRD'(1);
      for (int t = 0; t < NUM_TRD; t++) pc_q[t] <= (t == 0) ? RESET_PC : 32'h0;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      ins_valid <= 1'b0;
      ins       <= 32'h0;
      ins_pc    <= 32'h0;
      ins_tid   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      squash_q  <= squash_d;
      active_q  <= active_d;
      for (int t = 0; t < NUM_TRD; t++) pc_q[t] <= pc_d[t];
      imem_req  <= imem_req_d;
      imem_addr <= imem_addr_d;
      ins_valid <= ins_valid_d;
      ins       <= ins_d;
      ins_pc    <= ins_pc_d;
      ins_tid   <= ins_tid_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  localparam int          NT   = 4;
  localparam logic [31:0] RPC  = 32'h100;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [1:0]  ins_tid;
  logic        redirect_valid;
  logic [1:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        trd_valid;
  logic [2:0]  trd_ctrl;
  logic [1:0]  trd_tid;
  logic [31:0] init_pc;
  logic [3:0]  active_mask;

  fetch #(.NUM_TRD(NT), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
    .ins_tid(ins_tid),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid),
    .redirect_pc(redirect_pc),
    .trd_valid(trd_valid), .trd_ctrl(trd_ctrl), .trd_tid(trd_tid),
    .init_pc(init_pc), .active_mask(active_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  tid;
    logic [31:0] pc;
    logic [31:0] ins;
  } xfer_t;
  xfer_t got_q[$];

  typedef struct {
    logic [2:0]  ctrl;
    logic [1:0]  tid;
    logic [31:0] pc;
    logic [3:0]  exp_mask;
  } tvec_t;
  tvec_t tbl[12];

  // memory behaviour knobs
  int gnt_lat  = 0;
  int rv_lat   = 1;
  bit rand_mem = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: grants after gnt_lat waiting cycles, answers rv_lat
  // cycles after the grant. Drives at posedge+1.
  initial begin
    int          req_wait;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    req_wait = 0; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
      if (rst) begin
        req_wait = 0;
        pend     = 1'b0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        if (imem_req) begin
          if (req_wait >= gnt_lat) begin
            imem_gnt  = 1'b1;
            req_wait  = 0;
            pend      = 1'b1;
            pend_cnt  = rv_lat - 1;
            pend_addr = imem_addr;
            if (rand_mem) begin
              gnt_lat = $urandom_range(0, 3);
              rv_lat  = $urandom_range(1, 3);
            end
          end else begin
            req_wait++;
          end
        end
      end
    end
  end

  // Negedge monitor: request stability and accepted-instruction log.
  initial begin
    bit          prev_pending;
    logic [31:0] prev_addr;
    prev_pending = 1'b0;
    prev_addr    = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pending = 1'b0;
      end else begin
        if (prev_pending) begin
          check("req_hold", {31'h0, imem_req}, 32'h1);
          check("addr_hold", imem_addr, prev_addr);
        end
        prev_pending = imem_req && !imem_gnt;
        prev_addr    = imem_addr;
        if (ins_valid && ins_ready)
          got_q.push_back('{tid: ins_tid, pc: ins_pc, ins: ins});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    trd_valid      = 1'b0;
    ins_ready      = rdy;
    tick();
    tick();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] t, input logic [31:0] p);
    trd_valid = 1'b1; trd_ctrl = c; trd_tid = t; init_pc = p;
    tick();
    trd_valid = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int i = 0;
    while (got_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (got_q.size() < n) begin
      failures++;
      $display("FAIL %s timeout got=%0d needed=%0d", name, got_q.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i = 0;
    @(negedge clk);
    while (!ins_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({name, "_valid_seen"}, {31'h0, ins_valid}, 32'h1);
  endtask

  task automatic expect_xfer(input int idx, input logic [1:0] tid, input logic [31:0] pc,
                             input string name);
    if (idx >= got_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing transfer %0d actual=none expected=pc 0x%0h", name, idx, pc);
    end else begin
      check($sformatf("%s[%0d].tid", name, idx), {30'h0, got_q[idx].tid}, {30'h0, tid});
      check($sformatf("%s[%0d].pc", name, idx), got_q[idx].pc, pc);
      check($sformatf("%s[%0d].ins", name, idx), got_q[idx].ins, mem_word(pc));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req"}, {31'h0, imem_req}, 32'h0);
    check({name, "_addr"}, imem_addr, 32'h0);
    check({name, "_valid"}, {31'h0, ins_valid}, 32'h0);
    check({name, "_ins"}, ins, 32'h0);
    check({name, "_pc"}, ins_pc, 32'h0);
    check({name, "_tid"}, {30'h0, ins_tid}, 32'h0);
    check({name, "_mask"}, {28'h0, active_mask}, 32'h1);
  endtask

  initial begin
    logic [31:0] cap_ins, cap_pc;
    logic [1:0]  cap_tid;
    logic [3:0]  en;
    logic [31:0] mpc [NT];
    int          tmp;
    int          last, nt;
    int          i;

    tbl[0]  = '{3'b010, 2'd0, 32'h0,   4'b0001};
    tbl[1]  = '{3'b111, 2'd2, 32'h500, 4'b0101};
    tbl[2]  = '{3'b001, 2'd0, 32'h0,   4'b0100};
    tbl[3]  = '{3'b001, 2'd0, 32'h0,   4'b0100};
    tbl[4]  = '{3'b010, 2'd3, 32'h0,   4'b1100};
    tbl[5]  = '{3'b000, 2'd2, 32'h0,   4'b1100};
    tbl[6]  = '{3'b100, 2'd3, 32'h0,   4'b1100};
    tbl[7]  = '{3'b011, 2'd2, 32'h0,   4'b1000};
    tbl[8]  = '{3'b101, 2'd0, 32'h0,   4'b1000};
    tbl[9]  = '{3'b110, 2'd1, 32'h0,   4'b1000};
    tbl[10] = '{3'b111, 2'd1, 32'h600, 4'b1010};
    tbl[11] = '{3'b011, 2'd3, 32'h0,   4'b0010};

    rst = 1'b1; ins_ready = 1'b1;
    redirect_valid = 1'b0; redirect_tid = 2'd0; redirect_pc = 32'h0;
    trd_valid = 1'b0; trd_ctrl = 3'b000; trd_tid = 2'd0; init_pc = 32'h0;

    // basic fetch timing from reset
    tick(); tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
    got_q.delete();
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", k), {31'h0, ins_valid},
            (k > 0 && k % 3 == 0) ? 32'h1 : 32'h0);
      if (k == 1) begin
        check("t1_req_c1", {31'h0, imem_req}, 32'h1);
        check("t1_addr_c1", imem_addr, RPC);
      end
    end
    wait_xfers(3, 20, "t1");
    for (int k = 0; k < 3; k++) expect_xfer(k, 2'd0, RPC + 32'(4 * k), "t1");

    // thread-control table
    do_reset(1'b0);
    foreach (tbl[j]) begin
      cmd(tbl[j].ctrl, tbl[j].tid, tbl[j].pc);
      @(negedge clk);
      check($sformatf("tbl%0d_mask", j), {28'h0, active_mask}, {28'h0, tbl[j].exp_mask});
      tick();
    end

    // round-robin over three threads
    do_reset(1'b1);
    cmd(3'b111, 2'd1, 32'h2000);
    cmd(3'b111, 2'd2, 32'h3000);
    wait_xfers(6, 100, "t2");
    expect_xfer(0, 2'd0, 32'h100,  "t2");
    expect_xfer(1, 2'd1, 32'h2000, "t2");
    expect_xfer(2, 2'd2, 32'h3000, "t2");
    expect_xfer(3, 2'd0, 32'h104,  "t2");
    expect_xfer(4, 2'd1, 32'h2004, "t2");
    expect_xfer(5, 2'd2, 32'h3004, "t2");
    check("t2_mask", {28'h0, active_mask}, 32'h7);

    // redirect while the fetch is waiting for data
    rv_lat = 3;
    do_reset(1'b1);
    i = 0;
    @(negedge clk);
    while (!(imem_req && imem_gnt) && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("t3_gnt_seen", {31'h0, imem_req && imem_gnt}, 32'h1);
    tick();
    redirect_valid = 1'b1; redirect_tid = 2'd0; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    rv_lat = 1;
    wait_xfers(2, 60, "t3");
    expect_xfer(0, 2'd0, 32'h400, "t3");
    expect_xfer(1, 2'd0, 32'h404, "t3");

    // decode stalls for five cycles
    do_reset(1'b0);
    wait_valid(30, "t4");
    cap_ins = ins; cap_pc = ins_pc; cap_tid = ins_tid;
    check("t4_pc", cap_pc, 32'h100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t4_ins_s%0d", k), ins, cap_ins);
      check($sformatf("t4_pc_s%0d", k), ins_pc, cap_pc);
      check($sformatf("t4_tid_s%0d", k), {30'h0, ins_tid}, {30'h0, cap_tid});
      check($sformatf("t4_noreq_s%0d", k), {31'h0, imem_req}, 32'h0);
    end
    tick();
    ins_ready = 1'b1;
    @(negedge clk);
    check("t4_noreq_acc", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    check("t4_req_next", {31'h0, imem_req}, 32'h1);
    check("t4_addr_next", imem_addr, 32'h104);
    check("t4_valid_next", {31'h0, ins_valid}, 32'h0);

    // sleep / kill of the held thread, then wake
    do_reset(1'b0);
    wait_valid(30, "t5a");
    tick();
    cmd(3'b111, 2'd1, 32'h2000);
    cmd(3'b001, 2'd0, 32'h0);
    @(negedge clk);
    check("t5_sleep_drop", {31'h0, ins_valid}, 32'h0);
    check("t5_mask_a", {28'h0, active_mask}, 32'h2);
    wait_valid(30, "t5b");
    check("t5_t1_tid", {30'h0, ins_tid}, 32'h1);
    check("t5_t1_pc", ins_pc, 32'h2000);
    check("t5_t1_ins", ins, mem_word(32'h2000));
    tick();
    cmd(3'b011, 2'd1, 32'h0);
    @(negedge clk);
    check("t5_kill_drop", {31'h0, ins_valid}, 32'h0);
    check("t5_mask_b", {28'h0, active_mask}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t5_idle_%0d", k), {31'h0, imem_req}, 32'h0);
    end
    tick();
    ins_ready = 1'b1;
    cmd(3'b010, 2'd1, 32'h0);
    wait_xfers(2, 60, "t5");
    expect_xfer(0, 2'd1, 32'h2004, "t5");
    expect_xfer(1, 2'd1, 32'h2008, "t5");

    // slow grant, then reset in the middle of the wait
    gnt_lat = 3; rv_lat = 3;
    do_reset(1'b1);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t6_req_c%0d", k), {31'h0, imem_req}, 32'h1);
      check($sformatf("t6_addr_c%0d", k), imem_addr, 32'h100);
    end
    check("t6_gnt_c4", {31'h0, imem_gnt}, 32'h1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    gnt_lat = 0; rv_lat = 1;
    tick();
    tick();
    rst = 1'b0;
    got_q.delete();
    wait_xfers(2, 40, "t6");
    expect_xfer(0, 2'd0, 32'h100, "t6");
    expect_xfer(1, 2'd0, 32'h104, "t6");

    // randomized memory timing and decode backpressure against a
    // round-robin transaction model
    for (int it = 0; it < 4; it++) begin
      rand_mem = 1'b1; gnt_lat = 0; rv_lat = 1;
      do_reset(1'b0);
      tmp = $urandom_range(0, 7);
      en  = (it == 0) ? 4'b1111 : {tmp[2:0], 1'b1};
      mpc[0] = RPC;
      for (int t = 1; t < NT; t++) begin
        mpc[t] = (it == 0 && t == 3) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        if (en[t]) cmd(3'b111, 2'(t), mpc[t]);
        else tick();
      end
      tick(); tick(); tick();
      i = 0;
      while (got_q.size() < 20 && i < 3000) begin
        ins_ready = ($urandom_range(0, 3) != 0);
        tick();
        i++;
      end
      ins_ready = 1'b0;
      checks++;
      if (got_q.size() < 20) begin
        failures++;
        $display("FAIL rnd%0d timeout got=%0d needed=20", it, got_q.size());
      end
      last = NT - 1;
      for (int n = 0; n < 20; n++) begin
        nt = last;
        for (int s = 1; s <= NT; s++) begin
          if (en[(last + s) % NT]) begin
            nt = (last + s) % NT;
            break;
          end
        end
        expect_xfer(n, 2'(nt), mpc[nt], $sformatf("rnd%0d", it));
        mpc[nt] = mpc[nt] + 32'd4;
        last = nt;
      end
    end
    rand_mem = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Multithreaded instruction fetch stage, directly upstream of the decoder. Holds one PC and one active bit per hardware thread, selects an active thread round-robin, and issues one instruction-memory request at a time. The returned 32-bit word goes into a one-entry output register tagged with PC and thread ID, and is handed to decode over a valid/ready handshake. Branch redirects and thread-control commands (init/sleep/wake/kill) from later stages update the PC table and squash stale fetches.

## Interface
- NUM_TRD, 4: number of hardware threads (power of 2, ≥2); TW = $clog2(NUM_TRD)
- RESET_PC, 32'h0: PC loaded into thread 0 at reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request valid; held stable until imem_gnt
- imem_addr  out  32  fetch PC
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; earliest one cycle after gnt; exactly one per gnt
- imem_rdata  in  32  instruction word
- ins_valid  out  1  output instruction valid
- ins_ready  in  1  decode accepts
- ins  out  32  instruction to decode
- ins_pc  out  32  PC of ins
- ins_tid  out  TW  thread of ins
- redirect_valid  in  1  branch/exception redirect
- redirect_tid  in  TW  target thread
- redirect_pc  in  32  new PC
- trd_valid  in  1  thread-control command valid
- trd_ctrl  in  3  001 sleep, 010 wake, 011 kill, 111 init; other codes ignored
- trd_tid  in  TW  target thread
- init_pc  in  32  start PC for init
- active_mask  out  NUM_TRD  per-thread active bits

## Operation
- Reset: pc[0]=RESET_PC, all other pc=0; active_mask=1 (thread 0 only); rr pointer=NUM_TRD-1; state IDLE; imem_req=0, imem_addr=0, ins_valid=0, ins=0, ins_pc=0, ins_tid=0; squash flag clear.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: if any active bit set, pick the first active thread scanning rr+1, rr+2, … (mod NUM_TRD). Set rr to that thread, load imem_addr=pc[t], go to REQ. No active thread: stay in IDLE.
- REQ: imem_req=1. On imem_gnt go to WAIT (imem_req=0 next cycle).
- WAIT: on imem_rvalid:
  - not squashed: capture ins/ins_pc/ins_tid, set pc[t]=fetched_pc+4 (32-bit wrap), go to HOLD.
  - squashed: discard, pc unchanged, go to IDLE.
- HOLD: ins_valid=1. When ins_ready=1, arbitrate as in IDLE in the same cycle. Go to REQ if a thread is found, else IDLE.
- Fetch is in flight in REQ/WAIT; held in HOLD.
- Squash: redirect, sleep or kill whose tid equals the in-flight tid sets the squash flag. The request still completes its handshake and the response is dropped. The flag clears on leaving WAIT.
- Same squash in HOLD: ins_valid drops next cycle, go to IDLE. If ins_ready is high in that same cycle, the transfer completes; decode's flush covers it.
- Redirect: pc[tid]=redirect_pc; active bit unchanged.
- init: active=1, pc=init_pc. wake: active=1, pc unchanged. sleep/kill: active=0, pc unchanged.
- Same tid, same cycle:
  - init beats redirect for pc.
  - sleep/kill plus redirect: pc=redirect_pc, active=0.
  - Update beats the +4 write-back to that tid in the same cycle.
- Commands apply even to a thread already in the target state; wake of an active thread is a no-op.

## Timing
- All outputs registered.
- Arbitration uses active_mask as registered at the start of the cycle; an init becomes visible to arbitration one cycle later.
- Best case, gnt in the first REQ cycle and rvalid one cycle later: IDLE (c0) → imem_req (c1) → rvalid (c2) → ins_valid (c3).
- Back-to-back with ins_ready=1 and zero-wait memory: one instruction every 3 cycles.
- active_mask updates one cycle after the command.
- Reset asserted mid-operation returns everything to reset values immediately. An outstanding memory response after reset deassertion is ignored (state IDLE).

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, ins_ready=1 → fetches 0x100, 0x104, 0x108 on thread 0; ins_valid at c3, c6, c9.
- init tid1 pc=0x2000, init tid2 pc=0x3000 → fetch order tid0, tid1, tid2, tid0…; each thread's PC advances by 4.
- Redirect tid0 to 0x400 while tid0 in WAIT → response dropped, no ins_valid for it; next tid0 fetch at 0x400.
- ins_ready=0 for 5 cycles in HOLD → ins/ins_pc/ins_tid stable, no new imem_req; on ready, next request the following cycle.
- Kill tid1 while tid1 in HOLD → ins_valid low next cycle; tid1 never selected again until wake; then resumes at its old PC.
- imem_gnt delayed 3 cycles, then reset pulsed during WAIT → imem_req and imem_addr stable until gnt; after reset all outputs at reset values and fetch restarts at RESET_PC.
